oam_dma: RTL and testbench

- Sprite OAM DMA controller on the CPU bus, triggered by a CPU write to $4014.
- Halts the CPU, takes over the address/data bus, and copies 256 bytes from CPU page $XX00-$XXFF to the PPU OAMDATA port ($2004).
- Sits beside the address decoder. Its bus outputs are muxed over the CPU's bus outputs while dma_active is high.

---
 rtl/nes_pkg.sv | 7 +
 rtl/oam_dma_if.sv | 23 ++
 rtl/cpu_cycle_parity.sv | 12 +
 rtl/oam_dma.sv | 101 ++++++++++
 tb/tb_oam_dma.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/nes_pkg.sv
// Shared NES bus definitions: DMA state encoding and fixed register addresses.
package nes_pkg;
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
endpackage

// File: rtl/oam_dma_if.sv
// CPU-side bus seen by the OAM DMA: CPU strobes/drives in, DMA takeover signals out.
interface oam_dma_if;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic [7:0]  bus_rdata;
    logic        dma_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_wdata;
    logic        dma_busy;

    modport master (
        input  cpu_ce, cpu_addr, cpu_rw, cpu_wdata, bus_rdata,
        output dma_halt, dma_active, dma_addr, dma_rw, dma_wdata, dma_busy
    );
    modport slave (
        output cpu_ce, cpu_addr, cpu_rw, cpu_wdata, bus_rdata,
        input  dma_halt, dma_active, dma_addr, dma_rw, dma_wdata, dma_busy
    );
endinterface

// File: rtl/cpu_cycle_parity.sv
// Get/put cycle parity: toggles once per CPU cycle from reset; put=1 marks a put (write) cycle.
module cpu_cycle_parity (
    input  logic clk,
    input  logic n_reset,
    input  logic cpu_ce,
    output logic put
);
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)    put <= 1'b0;
        else if (cpu_ce) put <= ~put;
    end
endmodule

// File: rtl/oam_dma.sv
// Sprite OAM DMA: on a write to the trigger address, halt the CPU and copy one
// source page to OAMDATA as alternating read/write CPU cycles.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int          XFER_LEN      = 256   // power of two, at most 256
) (
    input  logic      clk,
    input  logic      n_reset,
    oam_dma_if.master bus
);
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        put;
    logic        halt_q;
    logic        active_q;
    logic        rw_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        trigger;

    cpu_cycle_parity u_parity (
        .clk     (clk),
        .n_reset (n_reset),
        .cpu_ce  (bus.cpu_ce),
        .put     (put)
    );

    assign trigger = !bus.cpu_rw && (bus.cpu_addr == TRIGGER_ADDR);

    // Bus outputs are registered from the next state so they are valid for the whole CPU cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            halt_q   <= 1'b0;
            active_q <= 1'b0;
            rw_q     <= 1'b1;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
        end else if (bus.cpu_ce) begin
            case (state)
                IDLE: if (trigger) begin
                    page   <= bus.cpu_wdata;
                    idx    <= 8'h00;
                    halt_q <= 1'b1;
                    state  <= HALT;
                end
                // CPU only freezes on a read; a put cycle here means the next one is a get.
                HALT: if (bus.cpu_rw) begin
                    if (put) begin
                        state    <= READ;
                        active_q <= 1'b1;
                        rw_q     <= 1'b1;
                        addr_q   <= {page, idx};
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    active_q <= 1'b1;
                    rw_q     <= 1'b1;
                    addr_q   <= {page, idx};
                end
                READ: begin
                    wdata_q <= bus.bus_rdata;
                    rw_q    <= 1'b0;
                    addr_q  <= OAM_DATA_ADDR;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        halt_q   <= 1'b0;
                        active_q <= 1'b0;
                    end else begin
                        idx    <= idx + 8'd1;
                        rw_q   <= 1'b1;
                        addr_q <= {page, idx + 8'd1};
                        state  <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dma_halt   = halt_q;
    assign bus.dma_active = active_q;
    assign bus.dma_rw     = rw_q;
    assign bus.dma_addr   = addr_q;
    assign bus.dma_wdata  = wdata_q;
    assign bus.dma_busy   = (state != IDLE);
endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: cycle-level transfer model plus directed transfers and literal checks.
module tb_oam_dma;
    logic clk = 1'b0;
    logic n_reset;
    oam_dma_if bus ();

    oam_dma dut (.clk(clk), .n_reset(n_reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    assign bus.bus_rdata = mem_f(bus.dma_active ? bus.dma_addr : bus.cpu_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: transfer described by its page, the cycle of the first read, and cycle arithmetic.
    int          cyc = 0;
    bit          m_busy = 0, m_wait = 0;
    logic [7:0]  m_page = 8'h00;
    int          first_rd = 0, k = 0, trig_cyc = 0;
    bit          e_act, e_rw;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    int          halt_cnt = 0, rd_cnt = 0, wr_cnt = 0, bad_pg = 0, first_cyc = 0;
    logic [15:0] first_rd_addr = 16'h0, last_rd_addr = 16'h0;

    always @(negedge clk) begin
        if (!n_reset) begin
            cyc = 0; m_busy = 0; m_wait = 0;
        end else if (bus.cpu_ce) begin
            e_act = 0; e_rw = 1; e_addr = 16'h0; e_wd = 8'h0; k = 0;
            if (m_busy && !m_wait && cyc >= first_rd) begin
                k      = cyc - first_rd;
                e_act  = 1;
                e_rw   = (k % 2 == 0);
                e_addr = e_rw ? {m_page, 8'(k / 2)} : 16'h2004;
                e_wd   = mem_f({m_page, 8'(k / 2)});
            end
            chk("busy",   32'(bus.dma_busy),   32'(m_busy));
            chk("halt",   32'(bus.dma_halt),   32'(m_busy));
            chk("active", 32'(bus.dma_active), 32'(e_act));
            if (e_act) begin
                chk("rw",   32'(bus.dma_rw),   32'(e_rw));
                chk("addr", 32'(bus.dma_addr), 32'(e_addr));
                if (!e_rw) chk("wdata", 32'(bus.dma_wdata), 32'(e_wd));
            end
            if (bus.dma_halt) halt_cnt++;
            if (bus.dma_active && bus.dma_rw) begin
                if (rd_cnt == 0) begin first_rd_addr = bus.dma_addr; first_cyc = cyc; end
                rd_cnt++;
                last_rd_addr = bus.dma_addr;
                if (bus.dma_addr[15:8] != m_page) bad_pg++;
            end
            if (bus.dma_active && !bus.dma_rw && bus.dma_addr == 16'h2004) wr_cnt++;
            if (m_busy && e_act && k == 511) begin
                m_busy = 0;
            end else if (!m_busy && !bus.cpu_rw && bus.cpu_addr == 16'h4014) begin
                m_busy = 1; m_wait = 1; m_page = bus.cpu_wdata; trig_cyc = cyc;
                halt_cnt = 0; rd_cnt = 0; wr_cnt = 0; bad_pg = 0;
            end else if (m_busy && m_wait && bus.cpu_rw) begin
                m_wait   = 0;
                first_rd = cyc + ((cyc % 2 == 1) ? 1 : 2);
            end
            cyc++;
        end
    end

    // One CPU cycle = three clks, cpu_ce high on the last one.
    task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
        bus.cpu_addr = a; bus.cpu_rw = rw; bus.cpu_wdata = d; bus.cpu_ce = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cpu_ce = 1'b1;
        @(posedge clk); #1;
        bus.cpu_ce = 1'b0;
    endtask

    task automatic idle();
        cpu_cycle(16'h8000, 1'b1, 8'h00);
    endtask

    // Trigger on a cycle of the given parity (0 = trigger on a get cycle).
    task automatic start(input logic [7:0] pg, input int par);
        while ((cyc % 2) != par) idle();
        cpu_cycle(16'h4014, 1'b0, pg);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (bus.dma_busy && n < 600) begin idle(); n++; end
        chk({nm, "_done"}, 32'(bus.dma_busy), 32'd0);
        chk({nm, "_halt_after"}, 32'(bus.dma_halt), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 1'b0;
        bus.cpu_ce = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_rw = 1'b1; bus.cpu_wdata = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_halt",   32'(bus.dma_halt),   32'd0);
        chk("rst_active", 32'(bus.dma_active), 32'd0);
        chk("rst_busy",   32'(bus.dma_busy),   32'd0);
        chk("rst_rw",     32'(bus.dma_rw),     32'd1);
        chk("rst_addr",   32'(bus.dma_addr),   32'h0000);
        chk("rst_wdata",  32'(bus.dma_wdata),  32'h00);
        n_reset = 1'b1;
        repeat (2) idle();

        // HALT lands on a put cycle: no ALIGN.
        start(8'h02, 0);
        chk("t1_busy_start", 32'(bus.dma_busy), 32'd1);
        drain("t1");
        chk("t1_halt_cnt",  32'(halt_cnt), 32'd513);
        chk("t1_rd_cnt",    32'(rd_cnt),   32'd256);
        chk("t1_wr_cnt",    32'(wr_cnt),   32'd256);
        chk("t1_first_rd",  32'(first_rd_addr), 32'h0200);
        chk("t1_last_rd",   32'(last_rd_addr),  32'h02FF);
        chk("t1_rd_delay",  32'(first_cyc - trig_cyc), 32'd2);

        // HALT lands on a get cycle: exactly one ALIGN, first READ still a get.
        idle();
        start(8'h05, 1);
        drain("t2");
        chk("t2_halt_cnt",  32'(halt_cnt), 32'd514);
        chk("t2_first_rd",  32'(first_rd_addr), 32'h0500);
        chk("t2_rd_delay",  32'(first_cyc - trig_cyc), 32'd3);
        chk("t2_rd_parity", 32'(first_cyc % 2), 32'd0);

        // CPU still writing for two cycles after the trigger.
        start(8'h06, 0);
        cpu_cycle(16'h0000, 1'b0, 8'h11);
        cpu_cycle(16'h0001, 1'b0, 8'h22);
        chk("t3_hold_halt",   32'(bus.dma_halt),   32'd1);
        chk("t3_hold_active", 32'(bus.dma_active), 32'd0);
        drain("t3");
        chk("t3_halt_cnt",  32'(halt_cnt), 32'd515);
        chk("t3_rd_delay",  32'(first_cyc - trig_cyc), 32'd4);

        // Re-trigger during a transfer is ignored.
        start(8'h03, 0);
        repeat (20) idle();
        cpu_cycle(16'h4014, 1'b0, 8'h07);
        drain("t4");
        chk("t4_bad_pg",   32'(bad_pg), 32'd0);
        chk("t4_first_rd", 32'(first_rd_addr), 32'h0300);
        chk("t4_last_rd",  32'(last_rd_addr),  32'h03FF);
        chk("t4_wr_cnt",   32'(wr_cnt), 32'd256);

        // Page $FF must not wrap into page $00.
        start(8'hFF, 0);
        drain("t5");
        chk("t5_last_rd", 32'(last_rd_addr), 32'hFFFF);
        chk("t5_rd_cnt",  32'(rd_cnt), 32'd256);
        chk("t5_bad_pg",  32'(bad_pg), 32'd0);

        // Asynchronous reset mid-transfer, then a fresh transfer from idx 0.
        start(8'h09, 0);
        begin
            int n = 0;
            while (wr_cnt < 100 && n < 400) begin idle(); n++; end
            chk("t6_reached_100", 32'(wr_cnt >= 100), 32'd1);
        end
        n_reset = 1'b0;
        #1;
        chk("t6_rst_halt",   32'(bus.dma_halt),   32'd0);
        chk("t6_rst_active", 32'(bus.dma_active), 32'd0);
        chk("t6_rst_busy",   32'(bus.dma_busy),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        start(8'h04, 0);
        drain("t6");
        chk("t6_first_rd", 32'(first_rd_addr), 32'h0400);
        chk("t6_rd_cnt",   32'(rd_cnt), 32'd256);
        chk("t6_halt_cnt", 32'(halt_cnt), 32'd513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
